// File: rtl/call_stack.sv
// Return-address LIFO for JCALL/JR: push stores PC+1, pop exposes the top as the JR target.
// The top entry is combinational from the count register, so a pushed value is usable on the next cycle.
module call_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTRW:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] IDX_ONE  = PTRW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PTRW-1:0]  w_wr_idx;
  logic [PTRW-1:0]  w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_replace;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_wr_idx  = r_count[PTRW-1:0];
  // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign w_top_idx = r_count[PTRW-1:0] - IDX_ONE;

  // A push+pop on an empty stack degenerates to a plain push.
  assign w_do_push = i_push && ((!i_pop && !w_full) || (i_pop && w_empty));
  assign w_replace = i_push && i_pop && !w_empty;
  assign w_do_pop  = i_pop && !i_push && !w_empty;
  assign w_ovf_evt = i_push && !i_pop && w_full;
  assign w_udf_evt = i_pop && !i_push && w_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end else if (w_replace) begin
      r_mem[w_top_idx] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_do_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_dout      = w_empty ? '0 : r_mem[w_top_idx];
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule
